// File: rtl/depar_egress_gate.sv
// -----------------------------------------------------------------------------
// depar_egress_gate
//
// Purpose:
//   This block sits between the deparser and the egress MAC/DMA. It forwards
//   complete AXI-Stream packets to the egress interface.
//   - A packet whose first beat has tuser[DROP_BIT] set is discarded.
//   - A packet longer than MAX_BEATS beats is cut short. Its MAX_BEATS-th beat
//     goes out with tlast forced, trunc_err pulses, and the rest of the
//     packet is discarded.
//   - The output is registered and backed by a one-entry skid register, so
//     s_axis_tready can be a flop and the block still moves one beat per cycle.
//
// Ports:
//   axis_clk, aresetn  clock and synchronous active-low reset
//   s_axis_*           input stream from the deparser (tdata/tkeep/tuser/
//                      tvalid/tlast in, tready out, tready registered)
//   m_axis_*           output stream to egress (tdata/tkeep/tuser/tvalid/
//                      tlast out, tready in)
//   trunc_err          one-cycle pulse when a packet is truncated
//
// Optional feature (macro EGRESS_STATS_EN):
//   Adds three wrapping 32-bit counters:
//     stat_pkt_cnt    forwarded tlast beats
//     stat_drop_cnt   dropped packets that enter DROP
//     stat_trunc_cnt  truncations
// -----------------------------------------------------------------------------
module depar_egress_gate #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int DROP_BIT           = 127,
  parameter int MAX_BEATS          = 64
) (
  input  logic                              axis_clk,
  input  logic                              aresetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic                              trunc_err
`ifdef EGRESS_STATS_EN
  ,
  output logic [31:0]                       stat_pkt_cnt,
  output logic [31:0]                       stat_drop_cnt,
  output logic [31:0]                       stat_trunc_cnt
`endif
);

  localparam int         KW          = C_AXIS_DATA_WIDTH / 8;
  localparam logic [7:0] MAX_BEATS_B = 8'(MAX_BEATS);

  typedef enum logic [1:0] {IDLE = 2'd0, PASS = 2'd1, DROP = 2'd2} state_e;

  state_e                          state_q, state_d;
  logic [7:0]                      beat_cnt_q, beat_cnt_d;
  logic                            s_ready_q, s_ready_d;
  logic                            trunc_q, trunc_d;

  logic                            out_valid_q, out_valid_d;
  logic                            out_last_q, out_last_d;
  logic [C_AXIS_DATA_WIDTH-1:0]    out_data_q, out_data_d;
  logic [KW-1:0]                   out_keep_q, out_keep_d;
  logic [C_AXIS_TUSER_WIDTH-1:0]   out_user_q, out_user_d;

  logic                            skid_valid_q, skid_valid_d;
  logic                            skid_last_q, skid_last_d;
  logic [C_AXIS_DATA_WIDTH-1:0]    skid_data_q, skid_data_d;
  logic [KW-1:0]                   skid_keep_q, skid_keep_d;
  logic [C_AXIS_TUSER_WIDTH-1:0]   skid_user_q, skid_user_d;

  logic s_acc;     // input beat transfers on this edge
  logic drain;     // output register empties on this edge
  logic fwd;       // accepted beat is forwarded
  logic fwd_last;  // forwarded beat carries tlast (real or forced)

  assign s_acc = s_axis_tvalid & s_ready_q;
  assign drain = out_valid_q & m_axis_tready;

  // Packet state machine, advanced only on accepted input beats.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    fwd        = 1'b0;
    fwd_last   = 1'b0;
    trunc_d    = 1'b0;
    if (s_acc) begin
      unique case (state_q)
        IDLE: begin
          beat_cnt_d = 8'd0;
          if (s_axis_tuser[DROP_BIT]) begin
            if (!s_axis_tlast) state_d = DROP;
          end else begin
            fwd      = 1'b1;
            fwd_last = s_axis_tlast;
            if (!s_axis_tlast) begin
              state_d    = PASS;
              beat_cnt_d = 8'd1;
            end
          end
        end
        PASS: begin
          fwd = 1'b1;
          if (s_axis_tlast) begin
            fwd_last   = 1'b1;
            state_d    = IDLE;
            beat_cnt_d = 8'd0;
          end else if (beat_cnt_q + 8'd1 == MAX_BEATS_B) begin
            // Runaway packet: close it here and discard its tail.
            fwd_last   = 1'b1;
            trunc_d    = 1'b1;
            state_d    = DROP;
            beat_cnt_d = beat_cnt_q + 8'd1;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end
        DROP: begin
          if (s_axis_tlast) begin
            state_d    = IDLE;
            beat_cnt_d = 8'd0;
          end
        end
        default: begin
          state_d    = IDLE;
          beat_cnt_d = 8'd0;
        end
      endcase
    end
  end

  // Output register plus skid register. The skid is only ever occupied when
  // the output register is also full, and tready is low while the skid holds
  // a beat, so no accept can happen with the skid occupied.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    out_user_d   = out_user_q;
    skid_valid_d = skid_valid_q;
    skid_last_d  = skid_last_q;
    skid_data_d  = skid_data_q;
    skid_keep_d  = skid_keep_q;
    skid_user_d  = skid_user_q;
    if (skid_valid_q) begin
      if (drain) begin
        out_valid_d  = 1'b1;
        out_last_d   = skid_last_q;
        out_data_d   = skid_data_q;
        out_keep_d   = skid_keep_q;
        out_user_d   = skid_user_q;
        skid_valid_d = 1'b0;
      end
    end else if (fwd) begin
      if (!out_valid_q || drain) begin
        out_valid_d = 1'b1;
        out_last_d  = fwd_last;
        out_data_d  = s_axis_tdata;
        out_keep_d  = s_axis_tkeep;
        out_user_d  = s_axis_tuser;
      end else begin
        skid_valid_d = 1'b1;
        skid_last_d  = fwd_last;
        skid_data_d  = s_axis_tdata;
        skid_keep_d  = s_axis_tkeep;
        skid_user_d  = s_axis_tuser;
      end
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
    s_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      beat_cnt_q   <= 8'd0;
      s_ready_q    <= 1'b0;
      trunc_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_user_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_last_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_keep_q  <= '0;
      skid_user_q  <= '0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      s_ready_q    <= s_ready_d;
      trunc_q      <= trunc_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      out_user_q   <= out_user_d;
      skid_valid_q <= skid_valid_d;
      skid_last_q  <= skid_last_d;
      skid_data_q  <= skid_data_d;
      skid_keep_q  <= skid_keep_d;
      skid_user_q  <= skid_user_d;
    end
  end

  assign s_axis_tready = s_ready_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tkeep  = out_keep_q;
  assign m_axis_tuser  = out_user_q;
  assign trunc_err     = trunc_q;

`ifdef EGRESS_STATS_EN
  logic        drop_start;
  logic [31:0] pkt_cnt_q, drop_cnt_q, trunc_cnt_q;

  // A dropped single-beat packet never leaves IDLE, so it is not counted.
  assign drop_start = s_acc & (state_q == IDLE) & s_axis_tuser[DROP_BIT] & ~s_axis_tlast;

  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      pkt_cnt_q   <= 32'd0;
      drop_cnt_q  <= 32'd0;
      trunc_cnt_q <= 32'd0;
    end else begin
      if (fwd && fwd_last) pkt_cnt_q   <= pkt_cnt_q + 32'd1;
      if (drop_start)      drop_cnt_q  <= drop_cnt_q + 32'd1;
      if (trunc_d)         trunc_cnt_q <= trunc_cnt_q + 32'd1;
    end
  end

  assign stat_pkt_cnt   = pkt_cnt_q;
  assign stat_drop_cnt  = drop_cnt_q;
  assign stat_trunc_cnt = trunc_cnt_q;
`endif

endmodule

// File: tb/tb_depar_egress_gate.sv
// -----------------------------------------------------------------------------
// tb_depar_egress_gate
//
// Purpose:
//   Self-checking bench for depar_egress_gate. It uses narrow widths and
//   MAX_BEATS=4.
//   - A packet-level model builds the expected egress beat list from each
//     packet's length and drop flag.
//   - A two-deep occupancy count predicts s_axis_tready and m_axis_tvalid.
//
// Ports: none (top level). Define EGRESS_STATS_EN to also check the counters.
// -----------------------------------------------------------------------------
module tb_depar_egress_gate;
  localparam int DW = 64;
  localparam int UW = 16;
  localparam int DB = 15;
  localparam int MB = 4;
  localparam int KW = DW / 8;

  typedef struct packed {
    logic          last;
    logic [UW-1:0] user;
    logic [KW-1:0] keep;
    logic [DW-1:0] data;
  } beat_t;

  logic          axis_clk = 1'b0;
  logic          aresetn;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic [UW-1:0] s_axis_tuser;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic          trunc_err;
`ifdef EGRESS_STATS_EN
  logic [31:0]   stat_pkt_cnt, stat_drop_cnt, stat_trunc_cnt;
`endif

  depar_egress_gate #(
    .C_AXIS_DATA_WIDTH (DW),
    .C_AXIS_TUSER_WIDTH(UW),
    .DROP_BIT          (DB),
    .MAX_BEATS         (MB)
  ) dut (
    .axis_clk     (axis_clk),
    .aresetn      (aresetn),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tuser (s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .trunc_err    (trunc_err)
`ifdef EGRESS_STATS_EN
    ,
    .stat_pkt_cnt  (stat_pkt_cnt),
    .stat_drop_cnt (stat_drop_cnt),
    .stat_trunc_cnt(stat_trunc_cnt)
`endif
  );

  always #5 axis_clk = ~axis_clk;

  int    checks_run = 0;
  int    checks_failed = 0;
  int    cyc = 0;
  int    held = 0;        // forwarded beats inside the DUT (0..2)
  int    acc_cnt = 0;     // accepted input beats
  int    trunc_seen = 0;
  int    exp_trunc = 0;
  int    st_pkt = 0, st_drop = 0, st_trunc = 0;
  int    rmode = 0;       // m_axis_tready pattern: 0 high, 1 toggle, 2 random, 3 low
  bit    occ_en = 1'b0;
  bit    cur_fwd = 1'b0;
  beat_t exp_q[$];

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks_run++;
    if (obs !== exp) begin
      checks_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge axis_clk) cyc <= cyc + 1;

  // Egress ready pattern generator.
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge axis_clk);
      #2;
      case (rmode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ~m_axis_tready;
        2:       m_axis_tready = 1'($urandom_range(1));
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard, stall stability, occupancy prediction, trunc pulses.
  initial begin
    bit    prev_stall = 1'b0;
    beat_t prev_beat = '0;
    beat_t obs, e;
    forever begin
      @(negedge axis_clk);
      if (!aresetn) begin
        prev_stall = 1'b0;
      end else begin
        obs = {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata};
        if (prev_stall) begin
          check_eq("hold_valid", 128'(m_axis_tvalid), 128'(1));
          check_eq("hold_beat", 128'(obs), 128'(prev_beat));
        end
        if (occ_en) begin
          check_eq("s_ready_occ", 128'(s_axis_tready), 128'(held != 2));
          check_eq("m_valid_occ", 128'(m_axis_tvalid), 128'(held != 0));
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_beat", 128'(1), 128'(0));
          end else begin
            e = exp_q.pop_front();
            check_eq("out_beat", 128'(obs), 128'(e));
          end
        end
        if (trunc_err) trunc_seen++;
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_beat  = obs;
        held = held + int'(s_axis_tvalid && s_axis_tready && cur_fwd)
                    - int'(m_axis_tvalid && m_axis_tready);
        if (s_axis_tvalid && s_axis_tready) acc_cnt++;
      end
    end
  end

  function automatic beat_t mk_beat(input bit first, input bit drop, input bit last);
    beat_t b;
    b.data = {$urandom, $urandom};
    b.keep = last ? KW'($urandom_range(255, 1)) : '1;
    b.user = UW'($urandom);
    if (first) b.user[DB] = drop;
    b.last = last;
    return b;
  endfunction

  // Present one beat and hold it until accepted (bounded).
  task automatic drive_beat(input beat_t b, input bit fwd, input int idle_pct);
    int n = 0;
    while (int'($urandom_range(99)) < idle_pct) begin
      s_axis_tvalid = 1'b0;
      @(posedge axis_clk); #1;
    end
    {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata} = b;
    cur_fwd       = fwd;
    s_axis_tvalid = 1'b1;
    @(negedge axis_clk);
    while (!s_axis_tready) begin
      n++;
      if (n > 500) begin
        check_eq("s_ready_timeout", 128'(0), 128'(1));
        s_axis_tvalid = 1'b0;
        return;
      end
      @(negedge axis_clk);
    end
    @(posedge axis_clk); #1;
    s_axis_tvalid = 1'b0;
  endtask

  // Packet-level reference: a dropped packet yields nothing; otherwise the
  // first min(len, MB) beats come out, the last of them with tlast.
  task automatic send_pkt(input int len, input bit drop, input int idle_pct);
    int    nf = (len < MB) ? len : MB;
    beat_t b, e;
    if (drop) begin
      if (len > 1) st_drop++;
    end else begin
      st_pkt++;
      if (len > MB) begin
        exp_trunc++;
        st_trunc++;
      end
    end
    for (int i = 0; i < len; i++) begin
      b = mk_beat(i == 0, drop, i == len - 1);
      if (!drop && i < nf) begin
        e      = b;
        e.last = (i == nf - 1);
        exp_q.push_back(e);
      end
      drive_beat(b, !drop && i < nf, idle_pct);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || held != 0) && n < 2000) begin
      @(negedge axis_clk);
      n++;
    end
    check_eq("drain", 128'(exp_q.size()), 128'(0));
    @(posedge axis_clk); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_m_valid"}, 128'(m_axis_tvalid), 128'(0));
    check_eq({tag, "_m_last"}, 128'(m_axis_tlast), 128'(0));
    check_eq({tag, "_m_payload"}, 128'({m_axis_tuser, m_axis_tkeep, m_axis_tdata}), 128'(0));
    check_eq({tag, "_trunc"}, 128'(trunc_err), 128'(0));
    check_eq({tag, "_s_ready"}, 128'(s_axis_tready), 128'(0));
  endtask

  initial begin
    beat_t b;
    int    a, t, n;
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tuser  = '0;
    repeat (3) @(posedge axis_clk);
    @(negedge axis_clk);
    check_reset_vals("rst");
    @(posedge axis_clk); #1;
    aresetn = 1'b1;
    @(posedge axis_clk);
    @(negedge axis_clk);
    check_eq("rst_release_s_ready", 128'(s_axis_tready), 128'(1));
    @(posedge axis_clk); #1;
    occ_en = 1'b1;

    // 3-beat packet with an empty buffer; first output one cycle after accept.
    $display("test: 3-beat packet latency");
    fork
      send_pkt(3, 1'b0, 0);
      begin
        a = 0; t = 0; n = 0;
        do begin @(negedge axis_clk); n++; end
        while (!(s_axis_tvalid && s_axis_tready) && n < 50);
        a = cyc;
        n = 0;
        do begin @(negedge axis_clk); n++; end
        while (!m_axis_tvalid && n < 50);
        t = cyc;
        check_eq("latency", 128'(t - a), 128'(1));
      end
    join
    wait_drain();

    $display("test: dropped 4-beat packet then 2-beat packet");
    send_pkt(4, 1'b1, 0);
    send_pkt(2, 1'b0, 0);
    wait_drain();

    $display("test: 7-beat packet truncated at %0d beats", MB);
    send_pkt(7, 1'b0, 0);
    send_pkt(3, 1'b0, 0);
    wait_drain();
    check_eq("trunc_pulses_a", 128'(trunc_seen), 128'(exp_trunc));

    $display("test: back-to-back 1-beat packets, egress ready toggling");
    rmode = 1;
    for (int i = 0; i < 12; i++) send_pkt(1, 1'b0, 0);
    rmode = 0;
    wait_drain();

    $display("test: egress stall of 10 cycles");
    rmode = 3;
    @(posedge axis_clk); #1;
    a = acc_cnt;
    fork
      send_pkt(5, 1'b0, 0);
      begin
        repeat (10) @(posedge axis_clk);
        #1;
        check_eq("stall_accepts", 128'(acc_cnt - a), 128'(2));
        rmode = 0;
      end
    join
    wait_drain();

    $display("test: reset during beat 2 of 5");
    b = mk_beat(1'b1, 1'b0, 1'b0);
    drive_beat(b, 1'b1, 0);
    b = mk_beat(1'b0, 1'b0, 1'b0);
    {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata} = b;
    s_axis_tvalid = 1'b1;
    occ_en  = 1'b0;
    aresetn = 1'b0;
    @(posedge axis_clk); #1;
    aresetn       = 1'b1;
    s_axis_tvalid = 1'b0;
    @(negedge axis_clk);
    check_reset_vals("midrst");
    exp_q.delete();
    held     = 0;
    st_pkt   = 0;
    st_drop  = 0;
    st_trunc = 0;
    @(negedge axis_clk);
    check_eq("midrst_s_ready", 128'(s_axis_tready), 128'(1));
    @(posedge axis_clk); #1;
    occ_en = 1'b1;
    send_pkt(4, 1'b0, 0);
    wait_drain();

    $display("test: random packets, random egress ready");
    rmode = 2;
    for (int i = 0; i < 40; i++)
      send_pkt(int'($urandom_range(7, 1)), ($urandom_range(3) == 0), 30);
    rmode = 0;
    wait_drain();
    check_eq("trunc_pulses", 128'(trunc_seen), 128'(exp_trunc));
`ifdef EGRESS_STATS_EN
    check_eq("stat_pkt", 128'(stat_pkt_cnt), 128'(st_pkt));
    check_eq("stat_drop", 128'(stat_drop_cnt), 128'(st_drop));
    check_eq("stat_trunc", 128'(stat_trunc_cnt), 128'(st_trunc));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks_run, checks_failed);
    $finish;
  end

endmodule
